// File: rtl/umbral_cfg_loader_pkg.sv
// Shared definitions for the threshold loader and the flow-control FSM it feeds:
// loader state encodings, host register address map and field widths.
package umbral_cfg_loader_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_LOAD      = 3'd1,
    ST_INIT_HOLD = 3'd2,
    ST_WAIT_IDLE = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } ldr_state_t;

  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 16;
  localparam int MF_W    = 4;
  localparam int VC_W    = 16;
  localparam int D_W     = 4;
  localparam int ERR_W   = 5;
  localparam int FCODE_W = ERR_W + 1;
  localparam int ICNT_W  = 4;
  localparam int TMR_W   = 8;

  localparam logic [ADDR_W-1:0] ADDR_MF = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_V0 = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_V1 = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_D0 = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_D1 = 3'd4;

  // Addresses above D1 decode to nothing and are flagged to the host.
  function automatic logic addr_is_mapped(input logic [ADDR_W-1:0] addr);
    return addr <= ADDR_D1;
  endfunction

endpackage

// File: rtl/umbral_cfg_loader_sat_counter.sv
// Saturating up-counter used as the idle-wait timeout. tc flags the cycle in
// which an enabled count reaches LIMIT on the next edge, so the owner can act
// on the same edge the count arrives there.
module sat_counter
  import umbral_cfg_loader_pkg::*;
#(
  parameter int CNT_W = TMR_W,
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(LIMIT - 1);
  localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(LIMIT);

  logic [CNT_W-1:0] count;

  // Count while enabled, hold at LIMIT rather than wrap; clear wins over enable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != MAX_VAL)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = en && !clr && (count >= TC_VAL);

endmodule

// File: rtl/umbral_cfg_loader.sv
// Host-facing threshold loader: shadow registers written over a valid/ready
// port, copied to the active threshold outputs on commit, followed by an init
// pulse to the flow-control FSM and a bounded wait for it to report idle.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_RESET     | just out of reset, nothing accepted yet
// ST_LOAD      | accepting shadow writes, waiting for first commit
// ST_INIT_HOLD | thresholds applied, init held high for INIT_CYCLES
// ST_WAIT_IDLE | init released, waiting for idle/active within IDLE_TIMEOUT
// ST_RUN       | FSM running; shadow writes and re-commit allowed
// ST_FAULT     | error or timeout seen; sticky until reset
module umbral_cfg_loader
  import umbral_cfg_loader_pkg::*;
#(
  parameter int INIT_CYCLES  = 2,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_valid,
  input  logic [ADDR_W-1:0]    cfg_addr,
  input  logic [DATA_W-1:0]    cfg_data,
  output logic                 cfg_ready,
  input  logic                 cfg_commit,
  output logic                 cfg_addr_err,
  output logic                 init,
  output logic [MF_W-1:0]      UmbralesMFs,
  output logic [2*VC_W-1:0]    UmbralesVCs,
  output logic [2*D_W-1:0]     UmbralesDs,
  input  logic                 idle_out_cond,
  input  logic                 active_out_cond,
  input  logic                 error_out_cond,
  input  logic [ERR_W-1:0]     error_full_cond,
  output logic                 busy,
  output logic                 running,
  output logic                 fault,
  output logic [FCODE_W-1:0]   fault_code
);

  localparam logic [ICNT_W-1:0] INIT_LOAD = ICNT_W'(INIT_CYCLES);

  ldr_state_t        state;
  logic [ICNT_W-1:0] init_cnt;

  logic [MF_W-1:0]   sh_mf, nx_mf;
  logic [VC_W-1:0]   sh_v0, nx_v0;
  logic [VC_W-1:0]   sh_v1, nx_v1;
  logic [D_W-1:0]    sh_d0, nx_d0;
  logic [D_W-1:0]    sh_d1, nx_d1;

  logic wr_en;
  logic tmr_en;
  logic tmr_clr;
  logic tmr_tc;

  assign wr_en   = cfg_valid && cfg_ready;
  assign tmr_en  = (state == ST_WAIT_IDLE);
  assign tmr_clr = (state != ST_WAIT_IDLE);

  // Shadow values including this cycle's write, so a same-cycle commit
  // picks up the freshly written data.
  always_comb begin
    nx_mf = sh_mf;
    nx_v0 = sh_v0;
    nx_v1 = sh_v1;
    nx_d0 = sh_d0;
    nx_d1 = sh_d1;
    if (wr_en) begin
      case (cfg_addr)
        ADDR_MF: nx_mf = cfg_data[MF_W-1:0];
        ADDR_V0: nx_v0 = cfg_data;
        ADDR_V1: nx_v1 = cfg_data;
        ADDR_D0: nx_d0 = cfg_data[D_W-1:0];
        ADDR_D1: nx_d1 = cfg_data[D_W-1:0];
        default: ;
      endcase
    end
  end

  // Shadow registers track the merged write values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sh_mf <= '0;
      sh_v0 <= '0;
      sh_v1 <= '0;
      sh_d0 <= '0;
      sh_d1 <= '0;
    end else begin
      sh_mf <= nx_mf;
      sh_v0 <= nx_v0;
      sh_v1 <= nx_v1;
      sh_d0 <= nx_d0;
      sh_d1 <= nx_d1;
    end
  end

  // One-cycle flag for an accepted write to an unmapped address.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cfg_addr_err <= 1'b0;
    end else begin
      cfg_addr_err <= wr_en && !addr_is_mapped(cfg_addr);
    end
  end

  sat_counter #(
    .CNT_W (TMR_W),
    .LIMIT (IDLE_TIMEOUT)
  ) u_idle_timer (
    .clk   (clk),
    .reset (reset),
    .en    (tmr_en),
    .clr   (tmr_clr),
    .tc    (tmr_tc)
  );

  // Sequencer with registered status outputs; error beats commit, idle and timeout.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_RESET;
      init_cnt    <= '0;
      init        <= 1'b0;
      cfg_ready   <= 1'b0;
      busy        <= 1'b0;
      running     <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= '0;
      UmbralesMFs <= '0;
      UmbralesVCs <= '0;
      UmbralesDs  <= '0;
    end else begin
      case (state)
        ST_RESET: begin
          state     <= ST_LOAD;
          cfg_ready <= 1'b1;
        end

        ST_LOAD, ST_RUN: begin
          if ((state == ST_RUN) && error_out_cond) begin
            state      <= ST_FAULT;
            fault      <= 1'b1;
            fault_code <= {1'b0, error_full_cond};
            running    <= 1'b0;
            cfg_ready  <= 1'b0;
          end else if (cfg_commit) begin
            state       <= ST_INIT_HOLD;
            UmbralesMFs <= nx_mf;
            UmbralesVCs <= {nx_v0, nx_v1};
            UmbralesDs  <= {nx_d0, nx_d1};
            init_cnt    <= INIT_LOAD;
            init        <= 1'b1;
            busy        <= 1'b1;
            running     <= 1'b0;
            cfg_ready   <= 1'b0;
          end
        end

        ST_INIT_HOLD: begin
          if (error_out_cond) begin
            state      <= ST_FAULT;
            fault      <= 1'b1;
            fault_code <= {1'b0, error_full_cond};
            init       <= 1'b0;
            busy       <= 1'b0;
            init_cnt   <= '0;
          end else if (init_cnt <= ICNT_W'(1)) begin
            state    <= ST_WAIT_IDLE;
            init     <= 1'b0;
            init_cnt <= '0;
          end else begin
            init_cnt <= init_cnt - ICNT_W'(1);
          end
        end

        ST_WAIT_IDLE: begin
          if (error_out_cond) begin
            state      <= ST_FAULT;
            fault      <= 1'b1;
            fault_code <= {1'b0, error_full_cond};
            busy       <= 1'b0;
          end else if (idle_out_cond || active_out_cond) begin
            state     <= ST_RUN;
            busy      <= 1'b0;
            running   <= 1'b1;
            cfg_ready <= 1'b1;
          end else if (tmr_tc) begin
            state      <= ST_FAULT;
            fault      <= 1'b1;
            fault_code <= {1'b1, error_full_cond};
            busy       <= 1'b0;
          end
        end

        ST_FAULT: begin
          state <= ST_FAULT;
        end

        default: begin
          state     <= ST_RESET;
          init      <= 1'b0;
          cfg_ready <= 1'b0;
          busy      <= 1'b0;
          running   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_umbral_cfg_loader.sv
// Directed bench for umbral_cfg_loader: expectations are queued as stimulus is
// applied and popped against DUT outputs one step after the clock edge.
module tb_umbral_cfg_loader;
  import umbral_cfg_loader_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic                cfg_valid;
  logic [ADDR_W-1:0]   cfg_addr;
  logic [DATA_W-1:0]   cfg_data;
  logic                cfg_ready;
  logic                cfg_commit;
  logic                cfg_addr_err;
  logic                init;
  logic [MF_W-1:0]     UmbralesMFs;
  logic [2*VC_W-1:0]   UmbralesVCs;
  logic [2*D_W-1:0]    UmbralesDs;
  logic                idle_out_cond;
  logic                active_out_cond;
  logic                error_out_cond;
  logic [ERR_W-1:0]    error_full_cond;
  logic                busy;
  logic                running;
  logic                fault;
  logic [FCODE_W-1:0]  fault_code;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  umbral_cfg_loader #(
    .INIT_CYCLES  (2),
    .IDLE_TIMEOUT (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cfg_valid       (cfg_valid),
    .cfg_addr        (cfg_addr),
    .cfg_data        (cfg_data),
    .cfg_ready       (cfg_ready),
    .cfg_commit      (cfg_commit),
    .cfg_addr_err    (cfg_addr_err),
    .init            (init),
    .UmbralesMFs     (UmbralesMFs),
    .UmbralesVCs     (UmbralesVCs),
    .UmbralesDs      (UmbralesDs),
    .idle_out_cond   (idle_out_cond),
    .active_out_cond (active_out_cond),
    .error_out_cond  (error_out_cond),
    .error_full_cond (error_full_cond),
    .busy            (busy),
    .running         (running),
    .fault           (fault),
    .fault_code      (fault_code)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL sb_underflow observed=%0h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_data  = d;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    reset           = 1'b0;
    cfg_valid       = 1'b0;
    cfg_addr        = '0;
    cfg_data        = '0;
    cfg_commit      = 1'b0;
    idle_out_cond   = 1'b0;
    active_out_cond = 1'b0;
    error_out_cond  = 1'b0;
    error_full_cond = '0;

    // Reset state
    step();
    step();
    push("rst_init", 32'd0);
    push("rst_ready", 32'd0);
    push("rst_busy", 32'd0);
    push("rst_fault", 32'd0);
    push("rst_fcode", 32'd0);
    push("rst_vcs", 32'd0);
    pop_cmp(32'(init));
    pop_cmp(32'(cfg_ready));
    pop_cmp(32'(busy));
    pop_cmp(32'(fault));
    pop_cmp(32'(fault_code));
    pop_cmp(UmbralesVCs);

    reset = 1'b1;
    push("load_ready", 32'd1);
    step();
    pop_cmp(32'(cfg_ready));

    // Load shadows, nothing visible until commit
    push("mf_addr_err", 32'd0);
    wr(ADDR_MF, 16'h000A);
    pop_cmp(32'(cfg_addr_err));
    wr(ADDR_V0, 16'h1234);
    wr(ADDR_V1, 16'h5678);
    wr(ADDR_D0, 16'h0003);
    wr(ADDR_D1, 16'h0007);
    push("precommit_vcs", 32'd0);
    pop_cmp(UmbralesVCs);

    push("commit_vcs", 32'h1234_5678);
    push("commit_ds", 32'h37);
    push("commit_mfs", 32'hA);
    push("commit_init", 32'd1);
    push("commit_busy", 32'd1);
    commit();
    pop_cmp(UmbralesVCs);
    pop_cmp(32'(UmbralesDs));
    pop_cmp(32'(UmbralesMFs));
    pop_cmp(32'(init));
    pop_cmp(32'(busy));

    push("init_cycle2", 32'd1);
    step();
    pop_cmp(32'(init));
    push("init_fall", 32'd0);
    push("wait_busy", 32'd1);
    step();
    pop_cmp(32'(init));
    pop_cmp(32'(busy));

    for (int i = 0; i < 3; i++) begin
      push("wait_running", 32'd0);
      step();
      pop_cmp(32'(running));
    end
    idle_out_cond = 1'b1;
    push("run_running", 32'd1);
    push("run_ready", 32'd1);
    step();
    idle_out_cond = 1'b0;
    pop_cmp(32'(running));
    pop_cmp(32'(cfg_ready));

    // Shadow write in RUN leaves active thresholds alone
    push("run_wr_vcs", 32'h1234_5678);
    wr(ADDR_V0, 16'hFFFF);
    pop_cmp(UmbralesVCs);

    // FIFO error in RUN
    error_full_cond = 5'b00100;
    error_out_cond  = 1'b1;
    push("err_fault", 32'd1);
    push("err_fcode", 32'h04);
    push("err_running", 32'd0);
    step();
    error_out_cond  = 1'b0;
    error_full_cond = '0;
    pop_cmp(32'(fault));
    pop_cmp(32'(fault_code));
    pop_cmp(32'(running));

    push("fault_sticky", 32'd1);
    push("fault_noinit", 32'd0);
    push("fault_hold_vcs", 32'h1234_5678);
    push("fault_hold_fcode", 32'h04);
    commit();
    step();
    pop_cmp(32'(fault));
    pop_cmp(32'(init));
    pop_cmp(UmbralesVCs);
    pop_cmp(32'(fault_code));

    // Reset clears faulted state and active values
    reset = 1'b0;
    push("rst2_vcs", 32'd0);
    push("rst2_mfs", 32'd0);
    push("rst2_fault", 32'd0);
    push("rst2_fcode", 32'd0);
    step();
    pop_cmp(UmbralesVCs);
    pop_cmp(32'(UmbralesMFs));
    pop_cmp(32'(fault));
    pop_cmp(32'(fault_code));
    reset = 1'b1;
    step();

    // Idle timeout: fault exactly 16 cycles after init falls
    push("to_init_hi", 32'd1);
    commit();
    pop_cmp(32'(init));
    step();
    push("to_init_lo", 32'd0);
    step();
    pop_cmp(32'(init));
    for (int i = 0; i < 15; i++) step();
    push("to_before", 32'd0);
    pop_cmp(32'(fault));
    push("to_fault", 32'd1);
    push("to_fcode", 32'h20);
    push("to_busy", 32'd0);
    step();
    pop_cmp(32'(fault));
    pop_cmp(32'(fault_code));
    pop_cmp(32'(busy));

    // Unmapped address and same-cycle write+commit
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    push("addr6_err", 32'd1);
    wr(3'd6, 16'hFFFF);
    pop_cmp(32'(cfg_addr_err));
    push("addr_err_pulse", 32'd0);
    step();
    pop_cmp(32'(cfg_addr_err));

    cfg_valid  = 1'b1;
    cfg_addr   = ADDR_V1;
    cfg_data   = 16'hBEEF;
    cfg_commit = 1'b1;
    push("wc_vcs", 32'h0000_BEEF);
    push("wc_mfs", 32'd0);
    push("wc_ds", 32'd0);
    push("wc_init", 32'd1);
    step();
    cfg_valid  = 1'b0;
    cfg_commit = 1'b0;
    pop_cmp(UmbralesVCs);
    pop_cmp(32'(UmbralesMFs));
    pop_cmp(32'(UmbralesDs));
    pop_cmp(32'(init));

    // Reset during INIT_HOLD
    reset = 1'b0;
    push("mid_rst_init", 32'd0);
    push("mid_rst_vcs", 32'd0);
    push("mid_rst_busy", 32'd0);
    push("mid_rst_ready", 32'd0);
    step();
    pop_cmp(32'(init));
    pop_cmp(UmbralesVCs);
    pop_cmp(32'(busy));
    pop_cmp(32'(cfg_ready));
    reset = 1'b1;
    push("mid_rst_load", 32'd1);
    step();
    pop_cmp(32'(cfg_ready));

    // Error beats idle in WAIT_IDLE
    commit();
    step();
    step();
    idle_out_cond   = 1'b1;
    error_out_cond  = 1'b1;
    error_full_cond = 5'b10001;
    push("prio_fault", 32'd1);
    push("prio_fcode", 32'h11);
    push("prio_running", 32'd0);
    step();
    idle_out_cond   = 1'b0;
    error_out_cond  = 1'b0;
    error_full_cond = '0;
    pop_cmp(32'(fault));
    pop_cmp(32'(fault_code));
    pop_cmp(32'(running));

    checks++;
    assert (sb.size() == 0)
    else begin
      failures++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
